// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-op and FSM state encodings for the control unit.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_CALL = 4'h6;
  localparam logic [3:0] OP_RET  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  function automatic logic [3:0] opcode_of(input logic [7:0] word);
    return word[7:4];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode from the latched instruction register.
// CALL/RET decode is present only when CONTROL_UNIT_CALL_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       zero_flag,
  output logic       branch,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       is_halt
);

  always_comb begin
    branch  = 1'b0;
    alu_op  = ALU_PASS;
    reg_we  = 1'b0;
    is_halt = 1'b0;
    case (opcode_of(ir))
      OP_LDI: begin reg_we = 1'b1; alu_op = ALU_PASS; end
      OP_ADD: begin reg_we = 1'b1; alu_op = ALU_ADD;  end
      OP_SUB: begin reg_we = 1'b1; alu_op = ALU_SUB;  end
      OP_JMP: branch = 1'b1;
      OP_JZ:  branch = zero_flag;
`ifdef CONTROL_UNIT_CALL_EN
      OP_CALL: branch = 1'b1;
      OP_RET:  branch = 1'b1;
`endif
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Two-cycle FETCH/EXEC sequencer with HALT state and retired-instruction counter.
// Define CONTROL_UNIT_CALL_EN to add single-level CALL/RET with a return register.
module control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instruction,
  input  logic [3:0] pc,
  input  logic       zero_flag,
  output logic       pc_en,
  output logic       branch,
  output logic [3:0] branchaddress,
  output logic [1:0] alu_op,
  output logic [3:0] imm,
  output logic       reg_we,
  output logic       halted,
  output logic [7:0] retired
);

  state_t     state;
  logic [7:0] ir_q;
  logic [7:0] retired_q;
  logic       dec_branch;
  logic [1:0] dec_alu_op;
  logic       dec_reg_we;
  logic       dec_halt;

`ifdef CONTROL_UNIT_CALL_EN
  logic [3:0] ret_q;
`else
  logic       unused_pc;
  assign unused_pc = ^pc;
`endif

  ctrl_decode u_decode (
    .ir        (ir_q),
    .zero_flag (zero_flag),
    .branch    (dec_branch),
    .alu_op    (dec_alu_op),
    .reg_we    (dec_reg_we),
    .is_halt   (dec_halt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
`ifdef CONTROL_UNIT_CALL_EN
      ret_q     <= '0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          ir_q  <= instruction;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          retired_q <= retired_q + 8'd1;
          state     <= dec_halt ? ST_HALT : ST_FETCH;
`ifdef CONTROL_UNIT_CALL_EN
          if (opcode_of(ir_q) == OP_CALL)
            ret_q <= pc;
`endif
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Outputs stay combinational: JZ must follow zero_flag within the EXEC
  // cycle and everything must drop to zero as soon as rst is high.
  always_comb begin
    pc_en         = 1'b0;
    branch        = 1'b0;
    branchaddress = '0;
    alu_op        = ALU_PASS;
    imm           = '0;
    reg_we        = 1'b0;
    halted        = 1'b0;
    retired       = '0;
    if (!rst) begin
      imm           = ir_q[3:0];
      branchaddress = ir_q[3:0];
      retired       = retired_q;
      case (state)
        ST_FETCH: pc_en = 1'b1;
        ST_EXEC: begin
          branch = dec_branch;
          alu_op = dec_alu_op;
          reg_we = dec_reg_we;
`ifdef CONTROL_UNIT_CALL_EN
          if (opcode_of(ir_q) == OP_RET)
            branchaddress = ret_q;
`endif
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; honours CONTROL_UNIT_CALL_EN.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instruction = 8'h00;
  logic [3:0] pc = 4'h0;
  logic       zero_flag = 1'b0;
  logic       pc_en;
  logic       branch;
  logic [3:0] branchaddress;
  logic [1:0] alu_op;
  logic [3:0] imm;
  logic       reg_we;
  logic       halted;
  logic [7:0] retired;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_ret = 8'd0;

  control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .pc            (pc),
    .zero_flag     (zero_flag),
    .pc_en         (pc_en),
    .branch        (branch),
    .branchaddress (branchaddress),
    .alu_op        (alu_op),
    .imm           (imm),
    .reg_we        (reg_we),
    .halted        (halted),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instruction = 8'h12;
    tick();
    #1;
    n_checks++;
    if ({pc_en, branch, branchaddress, alu_op, imm, reg_we, halted, retired} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_1: got %h expected 0",
               {pc_en, branch, branchaddress, alu_op, imm, reg_we, halted, retired});
    end
    tick();
    #1;
    n_checks++;
    if ({pc_en, branch, branchaddress, alu_op, imm, reg_we, halted, retired} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_2: got %h expected 0",
               {pc_en, branch, branchaddress, alu_op, imm, reg_we, halted, retired});
    end
    rst = 1'b0;
    exp_ret = 8'd0;
    #1;
    n_checks++;
    if ({pc_en, reg_we, branch, retired} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_fetch: got pc_en=%b reg_we=%b branch=%b retired=%0d expected 1 0 0 0",
               pc_en, reg_we, branch, retired);
    end
    tick();
    #1;
    n_checks++;
    if ({pc_en, reg_we, alu_op, imm} !== {1'b0, 1'b1, 2'b00, 4'h2}) begin
      n_fail++;
      $display("FAIL ldi_exec: got pc_en=%b reg_we=%b alu_op=%b imm=%h expected 0 1 00 2",
               pc_en, reg_we, alu_op, imm);
    end
    tick();
    exp_ret = 8'd1;
    #1;
    n_checks++;
    if ({pc_en, reg_we, retired} !== {1'b1, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL ldi_retire: got pc_en=%b reg_we=%b retired=%0d expected 1 0 1",
               pc_en, reg_we, retired);
    end
  endtask

  task automatic test_jmp();
    instruction = 8'h49;
    tick();
    #1;
    n_checks++;
    if ({branch, branchaddress, pc_en} !== {1'b1, 4'h9, 1'b0}) begin
      n_fail++;
      $display("FAIL jmp_exec: got branch=%b addr=%h pc_en=%b expected 1 9 0",
               branch, branchaddress, pc_en);
    end
    tick();
    exp_ret++;
    #1;
    n_checks++;
    if ({branch, pc_en, retired} !== {1'b0, 1'b1, exp_ret}) begin
      n_fail++;
      $display("FAIL jmp_after: got branch=%b pc_en=%b retired=%0d expected 0 1 %0d",
               branch, pc_en, retired, exp_ret);
    end
  endtask

  task automatic test_jz();
    zero_flag = 1'b0;
    instruction = 8'h53;
    tick();
    #1;
    n_checks++;
    if ({branch, branchaddress} !== {1'b0, 4'h3}) begin
      n_fail++;
      $display("FAIL jz_not_taken: got branch=%b addr=%h expected 0 3", branch, branchaddress);
    end
    tick();
    exp_ret++;
    zero_flag = 1'b1;
    #1;
    n_checks++;
    if (branch !== 1'b0) begin
      n_fail++;
      $display("FAIL jz_fetch_no_branch: got branch=%b expected 0", branch);
    end
    tick();
    #1;
    n_checks++;
    if ({branch, branchaddress} !== {1'b1, 4'h3}) begin
      n_fail++;
      $display("FAIL jz_taken: got branch=%b addr=%h expected 1 3", branch, branchaddress);
    end
    tick();
    exp_ret++;
    zero_flag = 1'b0;
  endtask

  task automatic test_alu();
    logic [7:0] ins [6];
    logic [2:0] exp [6];
    ins[0] = 8'h27; exp[0] = 3'b1_01;
    ins[1] = 8'h3C; exp[1] = 3'b1_10;
    ins[2] = 8'h1E; exp[2] = 3'b1_00;
    ins[3] = 8'h85; exp[3] = 3'b0_00;
    ins[4] = 8'h00; exp[4] = 3'b0_00;
    ins[5] = 8'hB4; exp[5] = 3'b0_00;
    for (int i = 0; i < 6; i++) begin
      instruction = ins[i];
      tick();
      #1;
      n_checks++;
      if ({reg_we, alu_op, imm, branch, pc_en} !== {exp[i], ins[i][3:0], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL alu_exec[%0d]: got reg_we=%b alu_op=%b imm=%h branch=%b pc_en=%b expected %b %b %h 0 0",
                 i, reg_we, alu_op, imm, branch, pc_en, exp[i][2], exp[i][1:0], ins[i][3:0]);
      end
      tick();
      exp_ret++;
      #1;
      n_checks++;
      if ({reg_we, alu_op, retired} !== {3'b000, exp_ret}) begin
        n_fail++;
        $display("FAIL alu_fetch[%0d]: got reg_we=%b alu_op=%b retired=%0d expected 0 00 %0d",
                 i, reg_we, alu_op, retired, exp_ret);
      end
    end
  endtask

  task automatic test_callret();
    logic [4:0] exp_call;
    logic [4:0] exp_ret_br;
`ifdef CONTROL_UNIT_CALL_EN
    exp_call = {1'b1, 4'hA};
    exp_ret_br = {1'b1, 4'h5};
`else
    exp_call = {1'b0, 4'hA};
    exp_ret_br = {1'b0, 4'h0};
`endif
    pc = 4'h5;
    instruction = 8'h6A;
    tick();
    #1;
    n_checks++;
    if ({branch, branchaddress} !== exp_call) begin
      n_fail++;
      $display("FAIL call: got branch=%b addr=%h expected %b %h",
               branch, branchaddress, exp_call[4], exp_call[3:0]);
    end
    tick();
    exp_ret++;
    pc = 4'h9;
    instruction = 8'h70;
    tick();
    #1;
    n_checks++;
    if ({branch, branchaddress} !== exp_ret_br) begin
      n_fail++;
      $display("FAIL ret: got branch=%b addr=%h expected %b %h",
               branch, branchaddress, exp_ret_br[4], exp_ret_br[3:0]);
    end
    tick();
    exp_ret++;
    pc = 4'h0;
  endtask

  task automatic test_halt();
    instruction = 8'hF0;
    tick();
    #1;
    n_checks++;
    if ({halted, pc_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_exec: got halted=%b pc_en=%b expected 0 0", halted, pc_en);
    end
    tick();
    exp_ret++;
    instruction = 8'h12;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({halted, pc_en, reg_we, branch, retired} !== {4'b1000, exp_ret}) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: got halted=%b pc_en=%b reg_we=%b branch=%b retired=%0d expected 1 0 0 0 %0d",
                 i, halted, pc_en, reg_we, branch, retired, exp_ret);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({halted, pc_en, retired} !== 10'd0) begin
      n_fail++;
      $display("FAIL halt_rst_during: got halted=%b pc_en=%b retired=%0d expected 0 0 0",
               halted, pc_en, retired);
    end
    tick();
    rst = 1'b0;
    exp_ret = 8'd0;
    #1;
    n_checks++;
    if ({halted, pc_en, retired} !== {2'b01, 8'd0}) begin
      n_fail++;
      $display("FAIL halt_rst_after: got halted=%b pc_en=%b retired=%0d expected 0 1 0",
               halted, pc_en, retired);
    end
  endtask

  task automatic test_wrap_and_rst_exec();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instruction = 8'h00;
    repeat (255) begin
      tick();
      tick();
    end
    #1;
    n_checks++;
    if (retired !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_255: got retired=%0d expected 255", retired);
    end
    tick();
    tick();
    #1;
    n_checks++;
    if (retired !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_0: got retired=%0d expected 0", retired);
    end
    instruction = 8'h49;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({branch, pc_en, reg_we, branchaddress} !== 7'd0) begin
      n_fail++;
      $display("FAIL rst_in_jmp_exec: got branch=%b pc_en=%b reg_we=%b addr=%h expected 0 0 0 0",
               branch, pc_en, reg_we, branchaddress);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({pc_en, branch, imm, retired} !== {2'b10, 4'h0, 8'd0}) begin
      n_fail++;
      $display("FAIL rst_in_jmp_after: got pc_en=%b branch=%b imm=%h retired=%0d expected 1 0 0 0",
               pc_en, branch, imm, retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_jmp();
    test_jz();
    test_alu();
    test_callret();
    test_halt();
    test_wrap_and_rst_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
